twiddle_gen_ctrl: RTL and testbench
===================================

Name: twiddle_gen_ctrl

Overview:
Sequences a shared external modular multiplier to fill the NTT twiddle-factor table for a requested transform length N = 2^log_n. It derives the stage root w = root^(2^(LOG_MAX-log_n)) mod p by repeated squaring. It then writes w^0 .. w^(N/2-1) into the table write port, one entry per multiplier result. It sits between the NTT top-level control, the modmul instance and the twiddle RAM.

Parameters:
W, 64, operand/modulus width in bits
LOG_MAX, 6, log2 of largest supported N; root is a primitive 2^LOG_MAX-th root of unity
ADDR_W, LOG_MAX-1 (minimum 1), table address width (N/2 entries max)
TIMEOUT, 64, cycles to wait for mm_done before abort (TWID_TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request; accepted only in IDLE
log_n  in  $clog2(LOG_MAX+1)  requested log2(N); sampled with start
root  in  W  primitive 2^LOG_MAX-th root mod p; sampled with start
modulus  in  W  p; sampled with start
busy  out  1  high from the cycle after acceptance until done/err
done  out  1  one-cycle pulse, table complete
err  out  1  one-cycle pulse, request rejected or aborted
mm_go  out  1  one-cycle multiplier issue strobe
mm_a  out  W  multiplier operand a
mm_b  out  W  multiplier operand b
mm_mod  out  W  latched modulus
mm_done  in  1  one-cycle result strobe from multiplier, any latency >= 1
mm_res  in  W  (a*b) mod p, valid with mm_done
wr_en  out  1  table write strobe
wr_addr  out  ADDR_W  table address
wr_data  out  W  table data

Behaviour:
- Reset: all outputs 0, state IDLE, internal regs (w, cur, idx, sq_cnt) 0. Reset mid-operation aborts immediately with no done/err pulse; the partially written table is left as-is.
- States: IDLE, SQ_ISSUE, SQ_WAIT, WR0, MUL_ISSUE, MUL_WAIT, FIN.
- IDLE: on start, latch root->w, modulus->mm_mod, log_n, and set sq_cnt = LOG_MAX-log_n.
  - If log_n==0 or log_n>LOG_MAX: pulse err next cycle, stay IDLE, busy stays 0.
  - Else: busy=1 next cycle; go to SQ_ISSUE if sq_cnt>0, otherwise WR0.
- SQ_ISSUE: mm_go=1 for one cycle, mm_a=mm_b=w; go to SQ_WAIT.
- SQ_WAIT: on mm_done, set w=mm_res and decrement sq_cnt; go to SQ_ISSUE if the new sq_cnt>0, otherwise WR0.
- WR0: wr_en=1, wr_addr=0, wr_data=1; cur=1, idx=1. Go to FIN if N/2==1 (log_n==1), otherwise MUL_ISSUE.
- MUL_ISSUE: mm_go=1, mm_a=cur, mm_b=w; go to MUL_WAIT.
- MUL_WAIT: on mm_done, in the same cycle drive wr_en=1, wr_addr=idx, wr_data=mm_res (combinational passthrough is forbidden; register them so the write appears one cycle after mm_done). Set cur=mm_res and increment idx; go to FIN if idx==N/2-1, otherwise MUL_ISSUE.
- FIN: done=1 for one cycle, busy=0 in the same cycle; return to IDLE.
- Timing:
  - Exactly one multiplication is outstanding at a time, since each depends on the previous result.
  - mm_a, mm_b and mm_mod hold stable from mm_go until mm_done.
  - wr_en pulses exactly N/2 times per job, with addresses strictly increasing 0..N/2-1.
- Boundaries and ignored events:
  - mm_done outside SQ_WAIT/MUL_WAIT is ignored.
  - start while busy is ignored; it does not restart or queue.
  - start coinciding with rst is lost.
  - Arithmetic is entirely delegated to the multiplier; no modular reduction happens in this block.
  - idx wraps only at completion, never mid-job.

Optional Feature:
TWID_TIMEOUT_EN:
- Defined: a counter clears on every mm_go and counts while in SQ_WAIT or MUL_WAIT. On reaching TIMEOUT without mm_done, the block pulses err, drops busy and returns to IDLE. A late mm_done after the abort is ignored.
- Undefined: the block waits indefinitely in the wait states, and err is driven only by invalid log_n.

Test Plan:
- Bench model: modmul with latency 3. p=17, LOG_MAX=4, root=3, log_n=4 -> no squarings; writes 1,3,9,10,13,5,15,11 at addr 0..7, then one done pulse, 7 mm_go total.
- Same config, log_n=3 -> one squaring (mm_a=mm_b=3, result 9); writes 1,9,13,15 at addr 0..3, then done.
- log_n=1 -> 3 squarings (3->9->13->16), then a single write addr0=1 and done. log_n=0 and log_n=5 -> err pulse, busy never rises, no mm_go, no wr_en.
- start re-asserted during MUL_WAIT of a log_n=4 job -> ignored; write sequence identical to the first scenario. mm_done injected in IDLE -> no state change.
- rst asserted after the 3rd write of a log_n=4 job -> next cycle all outputs 0 with no done/err. A new start with log_n=3 then completes correctly.
- TWID_TIMEOUT_EN, TIMEOUT=8: model never returns mm_done -> err 8 cycles after mm_go, busy drops. Without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/twiddle_gen_ctrl.sv
// ---------------------------------------------------------------------------
// twiddle_gen_ctrl
//
// Fills the NTT twiddle-factor table for a transform of length N = 2^log_n
// by driving a shared external modular multiplier, one operation at a time.
//
//   1. Derive the stage root w = root^(2^(LOG_MAX-log_n)) mod p by squaring
//      the supplied primitive 2^LOG_MAX-th root (LOG_MAX-log_n) times.
//   2. Write w^0 .. w^(N/2-1) to the table, one entry per multiplier result.
//
// All arithmetic happens in the multiplier; this block only sequences it.
//
// Optional build macro:
//   TWID_TIMEOUT_EN - when defined, a wait for mm_done longer than TIMEOUT
//                     cycles aborts the job with an err pulse. When not
//                     defined, the wait states wait indefinitely and the
//                     TIMEOUT parameter does not exist.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high (aborts silently)
//   start    in   one-cycle job request, accepted only when idle
//   log_n    in   requested log2(N), sampled with start
//   root     in   primitive 2^LOG_MAX-th root of unity mod p, sampled with start
//   modulus  in   p, sampled with start
//   busy     out  high from the cycle after acceptance until done/err
//   done     out  one-cycle pulse, table complete
//   err      out  one-cycle pulse, request rejected (or aborted on timeout)
//   mm_go    out  one-cycle multiplier issue strobe
//   mm_a     out  multiplier operand a (held until mm_done)
//   mm_b     out  multiplier operand b (held until mm_done)
//   mm_mod   out  latched modulus
//   mm_done  in   one-cycle multiplier result strobe, latency >= 1
//   mm_res   in   (mm_a*mm_b) mod p, valid with mm_done
//   wr_en    out  table write strobe
//   wr_addr  out  table address
//   wr_data  out  table data
// ---------------------------------------------------------------------------
module twiddle_gen_ctrl #(
  parameter int W       = 64,
  parameter int LOG_MAX = 6,
  parameter int ADDR_W  = (LOG_MAX > 2) ? LOG_MAX - 1 : 1,
  localparam int LOGN_W = $clog2(LOG_MAX + 1)
`ifdef TWID_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LOGN_W-1:0] log_n,
  input  logic [W-1:0]      root,
  input  logic [W-1:0]      modulus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mm_go,
  output logic [W-1:0]      mm_a,
  output logic [W-1:0]      mm_b,
  output logic [W-1:0]      mm_mod,
  input  logic              mm_done,
  input  logic [W-1:0]      mm_res,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    WR0,
    MUL_ISSUE,
    MUL_WAIT,
    FIN
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_w;       // current root; becomes the stage root after squaring
  logic [W-1:0]        r_cur;     // last power of w written to the table
  logic [ADDR_W-1:0]   r_idx;     // table address of the next product
  logic [LOGN_W-1:0]   r_sq_cnt;  // squarings still to perform
  logic [LOGN_W-1:0]   r_log_n;

`ifdef TWID_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     r_to_cnt;
`endif

  // N/2 is built one bit wider than the address so that log_n == LOG_MAX
  // (N/2 == 2^ADDR_W) does not overflow; the last index is N/2-1.
  logic [ADDR_W:0]     w_half;
  logic [ADDR_W-1:0]   w_last_idx;
  logic                w_log_n_bad;

  assign w_half      = {{ADDR_W{1'b0}}, 1'b1} << (r_log_n - LOGN_W'(1));
  assign w_last_idx  = w_half[ADDR_W-1:0] - ADDR_W'(1);
  assign w_log_n_bad = (log_n == '0) || (log_n > LOGN_W'(LOG_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_cur    <= '0;
      r_idx    <= '0;
      r_sq_cnt <= '0;
      r_log_n  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mm_go    <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_mod   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
`ifdef TWID_TIMEOUT_EN
      r_to_cnt <= '0;
`endif
    end else begin
      // Strobes default low so each assertion below is a single-cycle pulse.
      done  <= 1'b0;
      err   <= 1'b0;
      mm_go <= 1'b0;
      wr_en <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_w      <= root;
            mm_mod   <= modulus;
            r_log_n  <= log_n;
            r_sq_cnt <= LOGN_W'(LOG_MAX) - log_n;
            if (w_log_n_bad) begin
              err <= 1'b1;
            end else begin
              busy    <= 1'b1;
              r_state <= (log_n == LOGN_W'(LOG_MAX)) ? WR0 : SQ_ISSUE;
            end
          end
        end

        SQ_ISSUE: begin
          mm_go   <= 1'b1;
          mm_a    <= r_w;
          mm_b    <= r_w;
`ifdef TWID_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state <= SQ_WAIT;
        end

        SQ_WAIT: begin
          if (mm_done) begin
            r_w      <= mm_res;
            r_sq_cnt <= r_sq_cnt - LOGN_W'(1);
            r_state  <= (r_sq_cnt == LOGN_W'(1)) ? WR0 : SQ_ISSUE;
          end
`ifdef TWID_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end

        WR0: begin
          // w^0 = 1 needs no multiplication.
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= W'(1);
          r_cur   <= W'(1);
          r_idx   <= ADDR_W'(1);
          r_state <= (r_log_n == LOGN_W'(1)) ? FIN : MUL_ISSUE;
        end

        MUL_ISSUE: begin
          mm_go   <= 1'b1;
          mm_a    <= r_cur;
          mm_b    <= r_w;
`ifdef TWID_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (mm_done) begin
            // Result is registered into the write port, so the table write
            // lands one cycle after mm_done.
            wr_en   <= 1'b1;
            wr_addr <= r_idx;
            wr_data <= mm_res;
            r_cur   <= mm_res;
            r_idx   <= r_idx + ADDR_W'(1);
            r_state <= (r_idx == w_last_idx) ? FIN : MUL_ISSUE;
          end
`ifdef TWID_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end

        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_gen_ctrl.sv
// Bench for twiddle_gen_ctrl: p=17, LOG_MAX=4, root=3, modmul model latency 3.
module tb_twiddle_gen_ctrl;

  localparam int W       = 16;
  localparam int LOG_MAX = 4;
  localparam int ADDR_W  = 3;
  localparam int LOGN_W  = 3;
  localparam int P       = 17;
  localparam int LAT     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LOGN_W-1:0] log_n = '0;
  logic [W-1:0]      root = '0;
  logic [W-1:0]      modulus = '0;
  logic              busy, done, err, mm_go, wr_en;
  logic [W-1:0]      mm_a, mm_b, mm_mod, wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              mm_done;
  logic [W-1:0]      mm_res;

  // multiplier model plus a manual injection path for stray strobes
  logic              model_en = 1'b1;
  logic              model_done = 1'b0;
  logic [W-1:0]      model_res = '0;
  logic              inj_done = 1'b0;
  logic [W-1:0]      inj_res = '0;
  logic              pend = 1'b0;
  int                lat_cnt = 0;
  logic [W-1:0]      pres = '0;

  assign mm_done = model_done | inj_done;
  assign mm_res  = model_done ? model_res : inj_res;

  int errors = 0;
  int checks = 0;

  twiddle_gen_ctrl #(
    .W(W),
    .LOG_MAX(LOG_MAX)
`ifdef TWID_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .log_n(log_n), .root(root),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .mm_go(mm_go),
    .mm_a(mm_a), .mm_b(mm_b), .mm_mod(mm_mod), .mm_done(mm_done),
    .mm_res(mm_res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // mm_done rises 3 cycles after the cycle mm_go is high
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (mm_go && model_en) begin
      pend    <= 1'b1;
      lat_cnt <= LAT - 2;
      pres    <= W'((32'(mm_a) * 32'(mm_b)) % 32'(mm_mod));
    end else if (pend) begin
      if (lat_cnt == 0) begin
        model_done <= 1'b1;
        model_res  <= pres;
        pend       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // monitor
  int cyc = 0, go_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int go_cyc = 0, err_cyc = 0;
  logic [W-1:0] first_a = '0, last_a = '0, last_b = '0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [W-1:0]      wd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (mm_go) begin
      go_cnt++;
      if (go_cnt == 1) first_a = mm_a;
      last_a = mm_a;
      last_b = mm_b;
      go_cyc = cyc;
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    go_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic do_start(input logic [LOGN_W-1:0] ln, input logic [W-1:0] r);
    tick(1);
    start = 1'b1; log_n = ln; root = r; modulus = W'(P);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt != 0 || err_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({busy, done, err, mm_go, wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 00000", {busy, done, err, mm_go, wr_en});
    end
    checks++;
    if ({mm_a, mm_b, mm_mod, wr_data} !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: got a=%0d b=%0d mod=%0d wd=%0d wa=%0d required all 0",
               mm_a, mm_b, mm_mod, wr_data, wr_addr);
    end
    // start coinciding with rst is lost
    clear_mon();
    start = 1'b1; log_n = 3'd4; root = 16'd3; modulus = 16'd17;
    tick(1);
    start = 1'b0; rst = 1'b0;
    tick(5);
    checks++;
    if (busy_cnt != 0 || go_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL reset_start_lost: got busy_cycles=%0d go=%0d err=%0d required 0 0 0",
               busy_cnt, go_cnt, err_cnt);
    end
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_full_n16();
    logic [W-1:0] exp_d[8] = '{16'd1, 16'd3, 16'd9, 16'd10, 16'd13, 16'd5, 16'd15, 16'd11};
    bit ok;
    clear_mon();
    do_start(3'd4, 16'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL n16_busy_rise: got %b required 1", busy);
    end
    wait_end(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL n16_timeout: got no done/err required done"); end
    checks++;
    if (wa_q.size() != 8) begin
      errors++;
      $display("FAIL n16_wr_count: got %0d required 8", wa_q.size());
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL n16_wr%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wa_q[i], wd_q[i], i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || go_cnt != 7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL n16_ctrl: got done=%0d err=%0d go=%0d busy=%b required 1 0 7 0",
               done_cnt, err_cnt, go_cnt, busy);
    end
    $display("full_n16: %0d writes, %0d mm_go, %0d done", wa_q.size(), go_cnt, done_cnt);
  endtask

  task automatic test_one_square();
    logic [W-1:0] exp_d[4] = '{16'd1, 16'd9, 16'd13, 16'd15};
    bit ok;
    clear_mon();
    do_start(3'd3, 16'd3);
    wait_end(300, ok);
    checks++;
    if (!ok || first_a !== 16'd3) begin
      errors++;
      $display("FAIL sq1_first_op: got ok=%0d a=%0d required ok=1 a=3", ok, first_a);
    end
    checks++;
    if (wa_q.size() != 4 || go_cnt != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL sq1_counts: got wr=%0d go=%0d done=%0d required 4 4 1",
               wa_q.size(), go_cnt, done_cnt);
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL sq1_wr%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wa_q[i], wd_q[i], i, exp_d[i]);
      end
    end
    $display("one_square: %0d writes, %0d mm_go", wa_q.size(), go_cnt);
  endtask

  task automatic test_log1();
    bit ok;
    clear_mon();
    do_start(3'd1, 16'd3);
    wait_end(300, ok);
    // squarings 3->9->13->16: the third operand pair is 13,13
    checks++;
    if (!ok || go_cnt != 3 || last_a !== 16'd13 || last_b !== 16'd13) begin
      errors++;
      $display("FAIL log1_squares: got ok=%0d go=%0d a=%0d b=%0d required 1 3 13 13",
               ok, go_cnt, last_a, last_b);
    end
    checks++;
    if (wa_q.size() != 1 || done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL log1_counts: got wr=%0d done=%0d err=%0d required 1 1 0",
               wa_q.size(), done_cnt, err_cnt);
    end else begin
      checks++;
      if (wa_q[0] !== 3'd0 || wd_q[0] !== 16'd1) begin
        errors++;
        $display("FAIL log1_wr0: got addr=%0d data=%0d required 0 1", wa_q[0], wd_q[0]);
      end
    end
    $display("log1: %0d mm_go, %0d writes", go_cnt, wa_q.size());
  endtask

  task automatic test_invalid();
    logic [LOGN_W-1:0] bad[2] = '{3'd0, 3'd5};
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      do_start(bad[k], 16'd3);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL invalid%0d_pulse: got err=%b busy=%b required 1 0", bad[k], err, busy);
      end
      tick(10);
      checks++;
      if (err_cnt != 1 || busy_cnt != 0 || go_cnt != 0 || wa_q.size() != 0 || done_cnt != 0) begin
        errors++;
        $display("FAIL invalid%0d_quiet: got err=%0d busy=%0d go=%0d wr=%0d done=%0d required 1 0 0 0 0",
                 bad[k], err_cnt, busy_cnt, go_cnt, wa_q.size(), done_cnt);
      end
      $display("invalid log_n=%0d: err pulses %0d", bad[k], err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_d[8] = '{16'd1, 16'd3, 16'd9, 16'd10, 16'd13, 16'd5, 16'd15, 16'd11};
    bit ok;
    int guard;
    clear_mon();
    do_start(3'd4, 16'd3);
    guard = 0;
    while (go_cnt < 2 && guard < 100) begin tick(1); guard++; end
    // now in MUL_WAIT; a second request must be ignored
    start = 1'b1; log_n = 3'd3; root = 16'd5;
    tick(1);
    start = 1'b0;
    wait_end(300, ok);
    tick(10);
    checks++;
    if (!ok || wa_q.size() != 8 || go_cnt != 7 || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts: got ok=%0d wr=%0d go=%0d done=%0d busy=%b required 1 8 7 1 0",
               ok, wa_q.size(), go_cnt, done_cnt, busy);
    end
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_wr%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wa_q[i], wd_q[i], i, exp_d[i]);
      end
    end
    $display("back_to_back: %0d writes after ignored start", wa_q.size());
  endtask

  task automatic test_idle_done();
    clear_mon();
    inj_res = 16'd5; inj_done = 1'b1;
    tick(1);
    inj_done = 1'b0;
    tick(5);
    checks++;
    if (busy_cnt != 0 || go_cnt != 0 || wa_q.size() != 0 || done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL idle_done: got busy=%0d go=%0d wr=%0d done=%0d err=%0d required all 0",
               busy_cnt, go_cnt, wa_q.size(), done_cnt, err_cnt);
    end
    $display("idle_done: stray mm_done ignored");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_d[4] = '{16'd1, 16'd9, 16'd13, 16'd15};
    bit ok;
    int guard;
    clear_mon();
    do_start(3'd4, 16'd3);
    guard = 0;
    while (wa_q.size() < 3 && guard < 100) begin tick(1); guard++; end
    rst = 1'b1;
    tick(1);
    checks++;
    if ({busy, done, err, mm_go, wr_en} !== 5'b0 || mm_mod !== '0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got strobes=%b mod=%0d wa=%0d required 0",
               {busy, done, err, mm_go, wr_en}, mm_mod, wr_addr);
    end
    tick(2);
    rst = 1'b0;
    tick(5);
    checks++;
    if (wa_q.size() != 3 || done_cnt != 0 || err_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_abort: got wr=%0d done=%0d err=%0d required 3 0 0",
               wa_q.size(), done_cnt, err_cnt);
    end
    clear_mon();
    do_start(3'd3, 16'd3);
    wait_end(300, ok);
    checks++;
    if (!ok || wa_q.size() != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_rerun: got ok=%0d wr=%0d done=%0d required 1 4 1",
               ok, wa_q.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL rstmid_wr%0d: got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, wa_q[i], wd_q[i], i, exp_d[i]);
      end
    end
    $display("reset_mid: aborted after 3 writes, rerun wrote %0d", wa_q.size());
  endtask

  task automatic test_timeout();
    clear_mon();
    model_en = 1'b0;
    do_start(3'd4, 16'd3);
`ifdef TWID_TIMEOUT_EN
    begin
      bit ok;
      wait_end(100, ok);
      checks++;
      if (!ok || err_cnt != 1 || (err_cyc - go_cyc) != 8 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout_abort: got ok=%0d err=%0d delay=%0d busy=%b required 1 1 8 0",
                 ok, err_cnt, err_cyc - go_cyc, busy);
      end
      inj_res = 16'd7; inj_done = 1'b1;
      tick(1);
      inj_done = 1'b0;
      tick(5);
      checks++;
      if (busy !== 1'b0 || go_cnt != 1 || wa_q.size() != 1 || done_cnt != 0) begin
        errors++;
        $display("FAIL timeout_late_done: got busy=%b go=%0d wr=%0d done=%0d required 0 1 1 0",
                 busy, go_cnt, wa_q.size(), done_cnt);
      end
    end
`else
    tick(100);
    checks++;
    if (busy !== 1'b1 || err_cnt != 0 || done_cnt != 0 || go_cnt != 1) begin
      errors++;
      $display("FAIL no_timeout_wait: got busy=%b err=%0d done=%0d go=%0d required 1 0 0 1",
               busy, err_cnt, done_cnt, go_cnt);
    end
`endif
    $display("timeout: busy=%b err pulses=%0d", busy, err_cnt);
    model_en = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_full_n16();
    test_one_square();
    test_log1();
    test_invalid();
    test_back_to_back();
    test_idle_done();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
